// File: rtl/load_ext_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// load_ext_ctrl_pkg
// Shared size/state encodings and the request legality check for the load path.
// Revision: 1.0
// ============================================================================
package load_ext_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Request is rejected without a memory access: illegal size or misaligned.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_lane_ext.sv
`default_nettype none
// ============================================================================
// load_lane_ext
// Selects the addressed byte/half lane of a little-endian word and extends it.
// Revision: 1.0
// ============================================================================
module load_lane_ext
  import load_ext_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_data = 32'h0;
    case (i_size)
      SZ_BYTE: o_data = {{24{i_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_sext & w_half[15]}}, w_half};
      SZ_WORD: o_data = i_word;
      default: o_data = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_ext_ctrl.sv
`default_nettype none
// ============================================================================
// load_ext_ctrl
// Single-outstanding load sequencer: aligned read, timeout, lane extend, response.
// Revision: 1.0
// ============================================================================
module load_ext_ctrl
  import load_ext_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_sext,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_data,
  output logic              o_rsp_err
);

  localparam int                 c_CNT_W   = $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

  state_e              r_state;
  logic                r_req_ready;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_rsp_valid;
  logic [31:0]         r_rsp_data;
  logic                r_rsp_err;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [1:0]          r_lane_addr;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [31:0]         w_ext_data;

  load_lane_ext u_lane_ext (
    .i_word (i_mem_rdata),
    .i_addr (r_lane_addr),
    .i_size (r_size),
    .i_sext (r_sext),
    .o_data (w_ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
      r_lane_addr <= 2'b00;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_lane_addr <= i_req_addr[1:0];
            r_size      <= i_req_size;
            r_sext      <= i_req_sext;
            r_req_ready <= 1'b0;
            if (req_is_bad(i_req_size, i_req_addr[1:0])) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= 32'h0;
            end else begin
              r_state    <= ST_MEM;
              r_mem_req  <= 1'b1;
              r_mem_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
              r_cnt      <= '0;
            end
          end
        end
        ST_MEM: begin
          // An ack arriving on the expiry cycle still delivers data.
          if (i_mem_ack || (r_cnt == c_CNT_MAX)) begin
            r_state     <= ST_RESP;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !i_mem_ack;
            r_rsp_data  <= i_mem_ack ? w_ext_data : 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_load_ext_ctrl.sv
`default_nettype none
// ============================================================================
// tb_load_ext_ctrl
// Directed and randomized load sequences checked against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_load_ext_ctrl;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_req_addr = '0;
  logic [1:0]        i_req_size = 2'b00;
  logic              i_req_sext = 1'b0;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ack = 1'b0;
  logic [31:0]       i_mem_rdata = 32'h0;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [31:0]       o_rsp_data;
  logic              o_rsp_err;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  load_ext_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_size  (i_req_size),
    .i_req_sext  (i_req_sext),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
    int unsigned au;
    au = a;
    return (sz == 2'd3) || (sz == 2'd1 && (au % 2) != 0) || (sz == 2'd2 && (au % 4) != 0);
  endfunction

  // Lane value by shift/modulo, sign applied by subtracting the lane range.
  function automatic logic [31:0] model_data(input logic [31:0] a, input logic [1:0] sz,
                                             input logic sx, input logic [31:0] d);
    longint v;
    longint dv;
    int unsigned au;
    dv = longint'(d);
    au = a;
    case (sz)
      2'd0: begin
        v = (dv >> (8 * (au % 4))) % 256;
        if (sx && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = (dv >> (16 * ((au / 2) % 2))) % 65536;
        if (sx && v >= 32768) v = v - 65536;
      end
      2'd2:    v = dv;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ack_dly = MEM cycles without ack before the ack cycle; >= TIMEOUT means never ack.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic sx, input logic [31:0] d, input int ack_dly,
                         input int rsp_dly, input logic poke);
    logic        bad;
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] a_al;
    int          n_wait;
    bad  = model_err(a, sz);
    a_al = (a / 4) * 4;
    check({tag, "/req_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_size  = sz;
    i_req_sext  = sx;
    step();
    i_req_valid = 1'b0;
    i_req_addr  = $urandom;
    i_req_size  = 2'($urandom);
    i_req_sext  = 1'($urandom);
    check({tag, "/busy"}, 32'(o_req_ready), 32'd0);
    if (bad) begin
      exp_d = 32'h0;
      exp_e = 1'b1;
      check({tag, "/no_memreq"}, 32'(o_mem_req), 32'd0);
    end else begin
      check({tag, "/mem_req"}, 32'(o_mem_req), 32'd1);
      check({tag, "/mem_addr"}, o_mem_addr, a_al);
      check({tag, "/rsp_early"}, 32'(o_rsp_valid), 32'd0);
      n_wait = (ack_dly >= TIMEOUT) ? TIMEOUT - 1 : ack_dly;
      for (int k = 0; k < n_wait; k++) begin
        i_mem_rdata = $urandom;
        step();
        check({tag, "/mem_hold"}, 32'(o_mem_req), 32'd1);
        check({tag, "/addr_hold"}, o_mem_addr, a_al);
      end
      if (ack_dly < TIMEOUT) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = d;
        exp_d       = model_data(a, sz, sx, d);
        exp_e       = 1'b0;
      end else begin
        i_mem_rdata = $urandom;
        exp_d       = 32'h0;
        exp_e       = 1'b1;
      end
      step();
      i_mem_ack   = 1'b0;
      i_mem_rdata = $urandom;
      check({tag, "/mem_drop"}, 32'(o_mem_req), 32'd0);
      check({tag, "/mem_addr0"}, o_mem_addr, 32'd0);
    end
    check({tag, "/rsp_valid"}, 32'(o_rsp_valid), 32'd1);
    check({tag, "/rsp_data"}, o_rsp_data, exp_d);
    check({tag, "/rsp_err"}, 32'(o_rsp_err), 32'(exp_e));
    for (int r = 0; r < rsp_dly; r++) begin
      if (poke) begin
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0040;
        i_req_size  = 2'd2;
        i_mem_ack   = 1'b1;
      end
      step();
      check({tag, "/hold_valid"}, 32'(o_rsp_valid), 32'd1);
      check({tag, "/hold_data"}, o_rsp_data, exp_d);
      check({tag, "/hold_err"}, 32'(o_rsp_err), 32'(exp_e));
      check({tag, "/hold_rdy"}, 32'(o_req_ready), 32'd0);
      check({tag, "/hold_nomem"}, 32'(o_mem_req), 32'd0);
    end
    i_req_valid = 1'b0;
    i_mem_ack   = 1'b0;
    i_rsp_ready = 1'b1;
    step();
    i_rsp_ready = 1'b0;
    check({tag, "/rsp_done"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "/ready_back"}, 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    int          ad;

    rst_n = 1'b0;
    step();
    check("rst_mem_req", 32'(o_mem_req), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_mem_addr", o_mem_addr, 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);

    // mem_ack while idle must not produce anything
    i_mem_ack = 1'b1;
    step();
    i_mem_ack = 1'b0;
    check("idle_ack_ignored", 32'(o_rsp_valid), 32'd0);

    do_load("lb_03",  32'h1000_0003, 2'd0, 1'b1, 32'h80FF_1234, 3, 0, 1'b0);
    check("lb_03_model", model_data(32'h1000_0003, 2'd0, 1'b1, 32'h80FF_1234), 32'hFFFF_FF80);
    do_load("lhu_02", 32'h2000_0002, 2'd1, 1'b0, 32'h8001_7FFF, 1, 0, 1'b0);
    do_load("lh_02",  32'h2000_0002, 2'd1, 1'b1, 32'h8001_7FFF, 0, 1, 1'b0);
    do_load("lw_00",  32'h2000_0000, 2'd2, 1'b1, 32'h8001_7FFF, 2, 0, 1'b0);
    do_load("lh_01",  32'h3000_0001, 2'd1, 1'b1, 32'h1234_5678, 0, 0, 1'b0);
    do_load("lw_02",  32'h3000_0002, 2'd2, 1'b0, 32'h1234_5678, 0, 0, 1'b0);
    do_load("sz_11",  32'h3000_0000, 2'd3, 1'b0, 32'h1234_5678, 0, 0, 1'b0);
    do_load("tmo",    32'h4000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, TIMEOUT, 0, 1'b0);
    do_load("ack_15", 32'h4000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, TIMEOUT - 1, 0, 1'b0);
    do_load("stall5", 32'h5000_0001, 2'd0, 1'b1, 32'h0000_8000, 1, 5, 1'b1);

    // Reset in the middle of a memory access
    i_req_valid = 1'b1;
    i_req_addr  = 32'h6000_0008;
    i_req_size  = 2'd2;
    step();
    i_req_valid = 1'b0;
    step();
    step();
    check("mid_mem_req", 32'(o_mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(o_mem_req), 32'd0);
    check("arst_mem_addr", o_mem_addr, 32'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
      check("post_rst_no_mem", 32'(o_mem_req), 32'd0);
    end
    i_mem_ack = 1'b0;
    do_load("lbu_01", 32'h6000_0001, 2'd0, 1'b0, 32'h0000_AB00, 2, 0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      ra = $urandom;
      rs = 2'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (rs == 2'd1) ra[0] = 1'b0;
        if (rs == 2'd2) ra[1:0] = 2'b00;
      end
      ad = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 4));
      do_load("rand", ra, rs, 1'($urandom), $urandom, ad,
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
